// File: rtl/zacore_mem_arbiter_if.sv
// Channel-side and memory-side bus bundle for zacore_mem_arbiter.
// The arbiter uses the slave modport; the requesters plus memory model use master.
interface zacore_mem_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [NUM_CH-1:0]        i_ch_req;
  logic [NUM_CH-1:0]        i_ch_we;
  logic [NUM_CH*ADDR_W-1:0] i_ch_addr;
  logic [NUM_CH*DATA_W-1:0] i_ch_wdata;
  logic [NUM_CH*MASK_W-1:0] i_ch_mask;
  logic [NUM_CH-1:0]        o_ch_ack;
  logic [DATA_W-1:0]        o_rdata;

  logic                     o_mem_req;
  logic                     o_mem_we;
  logic [ADDR_W-1:0]        o_mem_addr;
  logic [DATA_W-1:0]        o_mem_wdata;
  logic [MASK_W-1:0]        o_mem_mask;
  logic                     i_mem_ack;
  logic [DATA_W-1:0]        i_mem_rdata;

  modport slave (
    input  i_ch_req, i_ch_we, i_ch_addr, i_ch_wdata, i_ch_mask, i_mem_ack, i_mem_rdata,
    output o_ch_ack, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask
  );

  modport master (
    output i_ch_req, i_ch_we, i_ch_addr, i_ch_wdata, i_ch_mask, i_mem_ack, i_mem_rdata,
    input  o_ch_ack, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/zacore_mem_arbiter.sv
// N-channel req/ack arbiter merging fetch/read/write traffic onto one memory port.
// Single outstanding transaction; fixed-priority or round-robin grant; all outputs registered.
module zacore_mem_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  localparam int GID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  zacore_mem_arbiter_if.slave bus,
  output logic               o_busy,
  output logic [GID_W-1:0]   o_grant_id
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [GID_W-1:0]  sel;

  // Walk candidates from farthest to nearest so the nearest active one wins.
  function automatic logic [GID_W-1:0] pick(input logic [NUM_CH-1:0] req,
                                            input logic [GID_W-1:0]  last);
    logic [GID_W-1:0] win;
    logic [GID_W-1:0] idx_g;
    int               idx;
    win = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx   = (RR_MODE != 0) ? (int'(last) + k) % NUM_CH : k - 1;
      idx_g = GID_W'(idx);
      if (req[idx_g]) win = idx_g;
    end
    return win;
  endfunction

  always_comb begin
    sel         = pick(bus.i_ch_req, ptr_q);
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    ch_ack_d    = '0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (|bus.i_ch_req) begin
          state_d     = BUSY;
          ptr_d       = sel;
          gid_d       = sel;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.i_ch_we[sel];
          mem_addr_d  = ADDR_W'(bus.i_ch_addr >> (int'(sel) * ADDR_W));
          mem_wdata_d = DATA_W'(bus.i_ch_wdata >> (int'(sel) * DATA_W));
          mem_mask_d  = bus.i_ch_we[sel] ? MASK_W'(bus.i_ch_mask >> (int'(sel) * MASK_W))
                                         : '0;
        end
      end
      BUSY: begin
        if (bus.i_mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          ch_ack_d  = NUM_CH'(1) << gid_q;
          if (!mem_we_q) rdata_d = bus.i_mem_rdata;
        end
      end
      // Requests are deliberately not sampled here so the requester can drop its req.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= GID_W'(NUM_CH - 1);
      gid_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      ch_ack_q    <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      ch_ack_q    <= ch_ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_ch_ack    = ch_ack_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_mask  = mem_mask_q;
  assign o_busy          = busy_q;
  assign o_grant_id      = gid_q;
endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Bench for zacore_mem_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios followed by randomized traffic against a transaction-level model.
module tb_zacore_mem_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int GW  = 2;
  localparam bit RR_SEL = 1'b0;
  localparam bit FP_SEL = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0] req_v    [2];
  logic           we_m     [2][NCH];
  logic [AW-1:0]  addr_m   [2][NCH];
  logic [DW-1:0]  wdata_m  [2][NCH];
  logic [MW-1:0]  mask_m   [2][NCH];
  logic           mack_v   [2];
  logic [DW-1:0]  mrdata_v [2];

  wire [NCH-1:0]  ack_w    [2];
  wire [DW-1:0]   rdata_w  [2];
  wire            mreq_w   [2];
  wire            mwe_w    [2];
  wire [AW-1:0]   maddr_w  [2];
  wire [DW-1:0]   mwdata_w [2];
  wire [MW-1:0]   mmask_w  [2];
  wire            busy_w   [2];
  wire [GW-1:0]   gid_w    [2];

  int             ptr_m    [2];
  logic [DW-1:0]  rdata_m  [2];
  int             n_checks = 0;
  int             n_fail   = 0;

  for (genvar s = 0; s < 2; s++) begin : g_dut
    zacore_mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign bus.i_ch_we[c]              = we_m[s][c];
      assign bus.i_ch_addr[c*AW +: AW]   = addr_m[s][c];
      assign bus.i_ch_wdata[c*DW +: DW]  = wdata_m[s][c];
      assign bus.i_ch_mask[c*MW +: MW]   = mask_m[s][c];
    end
    assign bus.i_ch_req    = req_v[s];
    assign bus.i_mem_ack   = mack_v[s];
    assign bus.i_mem_rdata = mrdata_v[s];
    assign ack_w[s]        = bus.o_ch_ack;
    assign rdata_w[s]      = bus.o_rdata;
    assign mreq_w[s]       = bus.o_mem_req;
    assign mwe_w[s]        = bus.o_mem_we;
    assign maddr_w[s]      = bus.o_mem_addr;
    assign mwdata_w[s]     = bus.o_mem_wdata;
    assign mmask_w[s]      = bus.o_mem_mask;

    zacore_mem_arbiter #(
      .NUM_CH (NCH),
      .ADDR_W (AW),
      .DATA_W (DW),
      .RR_MODE((s == 0) ? 1 : 0)
    ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus),
      .o_busy    (busy_w[s]),
      .o_grant_id(gid_w[s])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner by the grant rule: lowest index, or first active after the last grant.
  function automatic int model_pick(input bit sel, input logic [NCH-1:0] r);
    int c;
    for (int k = 1; k <= NCH; k++) begin
      c = sel ? k - 1 : (ptr_m[sel] + k) % NCH;
      if (r[2'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic rand_payload(input bit sel, input logic [1:0] c);
    we_m[sel][c]    = 1'($urandom_range(0, 1));
    addr_m[sel][c]  = $urandom;
    wdata_m[sel][c] = $urandom;
    mask_m[sel][c]  = MW'($urandom);
  endtask

  task automatic check_zero(input bit sel);
    check("rst_ack",   64'(ack_w[sel]),    64'd0);
    check("rst_req",   64'(mreq_w[sel]),   64'd0);
    check("rst_we",    64'(mwe_w[sel]),    64'd0);
    check("rst_addr",  64'(maddr_w[sel]),  64'd0);
    check("rst_wdata", 64'(mwdata_w[sel]), 64'd0);
    check("rst_mask",  64'(mmask_w[sel]),  64'd0);
    check("rst_rdata", 64'(rdata_w[sel]),  64'd0);
    check("rst_busy",  64'(busy_w[sel]),   64'd0);
    check("rst_gid",   64'(gid_w[sel]),    64'd0);
  endtask

  task automatic txn(input bit sel, input logic [NCH-1:0] r, input int lat,
                     input logic [DW-1:0] rd, input bit spur, output int g);
    logic [1:0]    gi;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [MW-1:0] exp_mask;
    req_v[sel] = r;
    g          = model_pick(sel, r);
    gi         = 2'(g);
    exp_we     = we_m[sel][gi];
    exp_addr   = addr_m[sel][gi];
    exp_wdata  = wdata_m[sel][gi];
    exp_mask   = exp_we ? mask_m[sel][gi] : '0;
    step();
    check("grant_id",    64'(gid_w[sel]),    64'(g));
    check("grant_req",   64'(mreq_w[sel]),   64'd1);
    check("grant_we",    64'(mwe_w[sel]),    64'(exp_we));
    check("grant_addr",  64'(maddr_w[sel]),  64'(exp_addr));
    check("grant_wdata", 64'(mwdata_w[sel]), 64'(exp_wdata));
    check("grant_mask",  64'(mmask_w[sel]),  64'(exp_mask));
    check("grant_busy",  64'(busy_w[sel]),   64'd1);
    check("grant_noack", 64'(ack_w[sel]),    64'd0);
    ptr_m[sel] = g;
    for (int i = 0; i < lat; i++) begin
      addr_m[sel][gi]  = $urandom;
      wdata_m[sel][gi] = $urandom;
      mask_m[sel][gi]  = MW'($urandom);
      we_m[sel][gi]    = ~we_m[sel][gi];
      step();
      check("hold_req",   64'(mreq_w[sel]),   64'd1);
      check("hold_we",    64'(mwe_w[sel]),    64'(exp_we));
      check("hold_addr",  64'(maddr_w[sel]),  64'(exp_addr));
      check("hold_wdata", 64'(mwdata_w[sel]), 64'(exp_wdata));
      check("hold_mask",  64'(mmask_w[sel]),  64'(exp_mask));
      check("hold_noack", 64'(ack_w[sel]),    64'd0);
    end
    mack_v[sel]   = 1'b1;
    mrdata_v[sel] = rd;
    step();
    if (!exp_we) rdata_m[sel] = rd;
    check("ack_pulse",   64'(ack_w[sel]),   64'(3'b001 << g));
    check("ack_req_clr", 64'(mreq_w[sel]),  64'd0);
    check("ack_rdata",   64'(rdata_w[sel]), 64'(rdata_m[sel]));
    check("ack_busy",    64'(busy_w[sel]),  64'd1);
    mack_v[sel]     = spur;
    mrdata_v[sel]   = $urandom;
    req_v[sel][gi]  = 1'b0;
    step();
    check("done_noack", 64'(ack_w[sel]),   64'd0);
    check("done_busy",  64'(busy_w[sel]),  64'd0);
    check("done_req",   64'(mreq_w[sel]),  64'd0);
    check("done_rdata", 64'(rdata_w[sel]), 64'(rdata_m[sel]));
    check("done_gid",   64'(gid_w[sel]),   64'(g));
    mack_v[sel] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int             g;
    int             order [6];
    logic [NCH-1:0] cur;
    logic [NCH-1:0] nr;
    order = '{0, 1, 2, 0, 1, 2};
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_v[s] = '0; mack_v[s] = 1'b0; mrdata_v[s] = '0;
      ptr_m[s] = NCH - 1; rdata_m[s] = '0;
      for (int c = 0; c < NCH; c++) begin
        we_m[s][c] = 1'b0; addr_m[s][c] = '0; wdata_m[s][c] = '0; mask_m[s][c] = '0;
      end
    end
    repeat (3) step();
    check_zero(RR_SEL);
    check_zero(FP_SEL);
    #3 rst_n = 1'b1;

    // Single read on ch1; the nonzero mask must not reach the memory side.
    we_m[RR_SEL][1] = 1'b0; addr_m[RR_SEL][1] = 32'h0000_1000;
    wdata_m[RR_SEL][1] = 32'hAAAA_5555; mask_m[RR_SEL][1] = 4'hF;
    txn(RR_SEL, 3'b010, 0, 32'hDEAD_BEEF, 1'b0, g);
    check("read_gid",   64'(gid_w[RR_SEL]),   64'd1);
    check("read_rdata", 64'(rdata_w[RR_SEL]), 64'h0000_0000_DEAD_BEEF);

    // Write on ch2 with a slow memory; read data must be left alone.
    we_m[RR_SEL][2] = 1'b1; addr_m[RR_SEL][2] = 32'h0000_0020;
    wdata_m[RR_SEL][2] = 32'h1234_5678; mask_m[RR_SEL][2] = 4'b0011;
    txn(RR_SEL, 3'b100, 4, 32'h0BAD_F00D, 1'b1, g);
    check("write_gid",   64'(gid_w[RR_SEL]),   64'd2);
    check("write_rdata", 64'(rdata_w[RR_SEL]), 64'h0000_0000_DEAD_BEEF);

    // Stray memory ack while idle.
    mack_v[RR_SEL] = 1'b1; mrdata_v[RR_SEL] = 32'h5555_AAAA;
    step();
    check("spur_ack",   64'(ack_w[RR_SEL]),   64'd0);
    check("spur_busy",  64'(busy_w[RR_SEL]),  64'd0);
    check("spur_req",   64'(mreq_w[RR_SEL]),  64'd0);
    check("spur_rdata", 64'(rdata_w[RR_SEL]), 64'h0000_0000_DEAD_BEEF);
    mack_v[RR_SEL] = 1'b0;

    // All three channels requesting continuously.
    for (int c = 0; c < NCH; c++) rand_payload(RR_SEL, 2'(c));
    for (int i = 0; i < 6; i++) begin
      txn(RR_SEL, 3'b111, $urandom_range(0, 2), $urandom, 1'b0, g);
      check("rr_order", 64'(gid_w[RR_SEL]), 64'(order[i]));
      rand_payload(RR_SEL, 2'(g));
    end
    req_v[RR_SEL] = '0;
    step();

    // Fixed priority: ch0 keeps winning over ch2 until ch0 goes quiet.
    rand_payload(FP_SEL, 2'd0);
    rand_payload(FP_SEL, 2'd2);
    txn(FP_SEL, 3'b101, 1, $urandom, 1'b0, g);
    check("fp_first", 64'(gid_w[FP_SEL]), 64'd0);
    rand_payload(FP_SEL, 2'd0);
    txn(FP_SEL, 3'b101, 0, $urandom, 1'b1, g);
    check("fp_again", 64'(gid_w[FP_SEL]), 64'd0);
    txn(FP_SEL, 3'b100, 2, $urandom, 1'b0, g);
    check("fp_low", 64'(gid_w[FP_SEL]), 64'd2);
    req_v[FP_SEL] = '0;
    step();

    // Random traffic on each instance in turn.
    for (int s = 0; s < 2; s++) begin
      cur = '0;
      for (int t = 0; t < 30; t++) begin
        nr = cur | NCH'($urandom_range(0, 7));
        if (nr == '0) nr = 3'b001 << $urandom_range(0, 2);
        for (int c = 0; c < NCH; c++)
          if (nr[2'(c)] && !cur[2'(c)]) rand_payload(1'(s), 2'(c));
        txn(1'(s), nr, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), g);
        cur = nr & ~(3'b001 << g);
      end
      req_v[s] = '0;
      step();
      check("rand_idle_busy", 64'(busy_w[s]), 64'd0);
      check("rand_idle_req",  64'(mreq_w[s]), 64'd0);
    end

    // Reset dropped in the middle of a transaction.
    rand_payload(RR_SEL, 2'd1);
    req_v[RR_SEL] = 3'b010;
    step();
    check("mid_busy", 64'(busy_w[RR_SEL]), 64'd1);
    check("mid_req",  64'(mreq_w[RR_SEL]), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check_zero(RR_SEL);
    check_zero(FP_SEL);
    mack_v[RR_SEL] = 1'b1;
    step();
    check_zero(RR_SEL);
    mack_v[RR_SEL] = 1'b0;
    #3 rst_n = 1'b1;
    ptr_m[RR_SEL] = NCH - 1; ptr_m[FP_SEL] = NCH - 1;
    rdata_m[RR_SEL] = '0;    rdata_m[FP_SEL] = '0;
    for (int c = 0; c < NCH; c++) rand_payload(RR_SEL, 2'(c));
    txn(RR_SEL, 3'b111, 0, $urandom, 1'b0, g);
    check("post_rst_gid", 64'(gid_w[RR_SEL]), 64'd0);
    req_v[RR_SEL] = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zacore_mem_arbiter.md
Name: zacore_mem_arbiter

Overview:
- Parametrised N-channel request/acknowledge arbiter that merges the core's instruction-fetch, data-read and data-write traffic onto one shared memory port.
- Sits between the zacore pipeline stages and the external memory interface.
- Replaces the three separate fetch/read/write req/ack pairs with one registered, single-outstanding transaction bus.
- Supports fixed-priority and round-robin grant modes.

Parameters:
NUM_CH, 3, number of requesting channels (2..8); channel 0 = fetch by convention
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ch_req  in  NUM_CH  per-channel request; held high with payload stable until that channel's ack
i_ch_we  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
i_ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel c at bits [c*ADDR_W +: ADDR_W]
i_ch_wdata  in  NUM_CH*DATA_W  packed write data
i_ch_mask  in  NUM_CH*(DATA_W/8)  packed byte write masks; bit 0 = byte 0
o_ch_ack  out  NUM_CH  one-cycle completion pulse to the granted channel
o_rdata  out  DATA_W  read data, valid in the ack cycle
o_mem_req  out  1  downstream request
o_mem_we  out  1  downstream write enable
o_mem_addr  out  ADDR_W  downstream address
o_mem_wdata  out  DATA_W  downstream write data
o_mem_mask  out  DATA_W/8  downstream byte mask; forced to 0 on reads
i_mem_ack  in  1  downstream completion; sampled only while o_mem_req is high
i_mem_rdata  in  DATA_W  downstream read data, valid with i_mem_ack
o_busy  out  1  high in BUSY and DONE states
o_grant_id  out  max(1,$clog2(NUM_CH))  index of the current or most recent grant

Behaviour:
- Reset: one clock, i_clk; asynchronous active-low reset, i_rst_n.
- While i_rst_n = 0, every output is 0 and the state is IDLE.
- The round-robin pointer (last granted channel) resets to NUM_CH-1, so channel 0 has first priority after reset.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any i_ch_req bit is set, select a channel g and move to BUSY.
  - On the same edge, register g's we, addr, wdata and mask (mask is zeroed if we = 0) into the o_mem_* registers, set o_mem_req = 1 and set o_grant_id = g.
  - With no request, remain in IDLE.
- Selection, RR_MODE = 0: lowest-indexed active request.
- Selection, RR_MODE = 1: first active request searching upward from pointer+1, wrapping modulo NUM_CH. The pointer updates to g on the grant edge.
- BUSY:
  - o_mem_* are held constant.
  - On i_mem_ack = 1: clear o_mem_req, pulse o_ch_ack[g] = 1 for the next cycle, capture i_mem_rdata into o_rdata if the transaction is a read, and go to DONE.
  - o_rdata holds its previous value on writes.
- DONE:
  - o_ch_ack[g] is high for exactly this one cycle.
  - Requests are not sampled here; this gives the requester one cycle to drop or replace i_ch_req.
  - Next state is always IDLE.
- Latency: with i_mem_ack returned in the first BUSY cycle, a request first seen high in cycle 0 is acked in cycle 2. Minimum spacing between consecutive grants is 3 cycles.
- Only one transaction is outstanding at a time. i_mem_ack in IDLE or DONE is ignored.
- Changes to a non-granted channel's request or payload have no effect until the next IDLE.
- The granted channel's payload is captured at grant, so later payload changes during BUSY are ignored.
- If the granted channel drops i_ch_req during BUSY (protocol violation), the transaction still completes and is acked.
- Reset asserted mid-transaction: the transaction is abandoned, all outputs clear immediately, and no ack is issued.
- o_ch_ack is one-hot or zero at all times.

Test Plan:
- Reset: hold i_rst_n = 0 mid-BUSY, then release -> all outputs 0 asynchronously; first grant after release goes to channel 0 when requests = 3'b111 (RR_MODE = 1).
- Single read: ch1 reads addr 0x0000_1000, memory acks in the first BUSY cycle with 0xDEADBEEF -> o_mem_mask = 0, o_ch_ack = 3'b010 in cycle 2, o_rdata = 0xDEADBEEF.
- Write: ch2 writes 0x1234_5678 with mask 4'b0011 to 0x20, memory waits 5 cycles -> o_mem_req high for 5 cycles with stable payload, then exactly one ack pulse on ch2, o_rdata unchanged.
- Round robin: all 3 channels hold requests continuously, re-raising after each ack -> grant order 0,1,2,0,1,2; no channel is acked twice before the others.
- Fixed priority: RR_MODE = 0, ch0 and ch2 both requesting -> ch0 is granted repeatedly while ch0 requests; ch2 is granted only when ch0 is idle.
- Spurious ack: i_mem_ack pulsed in IDLE and in DONE -> no o_ch_ack, state unchanged, o_rdata unchanged.
